// File: rtl/mem_port_arbiter.sv
// Shared-RAM arbiter for D (data), F (fetch) and L (loader) ports: fixed priority D > F > L,
// starvation promotion for F/L, bounded loader bus lock, and read-data routing to the owner.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              l_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              starve_evt
);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKED = 2'd1, COOLDOWN = 2'd2} lock_state_e;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);
  localparam logic [1:0] OWN_D      = 2'd1;
  localparam logic [1:0] OWN_F      = 2'd2;
  localparam logic [1:0] OWN_L      = 2'd3;

  lock_state_e state, state_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic        lock_active, cooldown;
  logic [7:0]  cnt_f, cnt_l;
  logic        f_starve, l_starve, l_elig;
  logic        vld_p1;
  logic [1:0]  own_p1;

  assign f_starve = (cnt_f == STARVE_LIM);
  assign l_starve = (cnt_l == STARVE_LIM);
  assign l_elig   = l_req && !cooldown;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state    <= UNLOCKED;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    case (state)
      UNLOCKED: begin
        if (l_gnt && l_lock) begin
          state_nxt    = LOCKED;
          lock_cnt_nxt = 8'd1;
        end
      end
      LOCKED: begin
        if (!l_lock) begin
          state_nxt = UNLOCKED;
        end else if (l_gnt) begin
          if (lock_cnt == LOCK_LIM) state_nxt = COOLDOWN;
          else                      lock_cnt_nxt = lock_cnt + 8'd1;
        end
      end
      COOLDOWN: state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  always_comb begin
    lock_active = (state == LOCKED);
    cooldown    = (state == COOLDOWN);
  end

  // A held lock owns the bus outright: D/F stay blocked even while L idles.
  always_comb begin
    d_gnt      = 1'b0;
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    starve_evt = 1'b0;
    if (!rst) begin
      if (lock_active) begin
        l_gnt = l_req;
      end else if (f_starve && f_req) begin
        f_gnt      = 1'b1;
        starve_evt = 1'b1;
      end else if (l_starve && l_elig) begin
        l_gnt      = 1'b1;
        starve_evt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else if (l_elig) begin
        l_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = d_gnt | f_gnt | l_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (f_gnt) begin
      mem_we    = f_we;
      mem_addr  = f_addr;
      mem_wdata = f_wdata;
    end else if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_f <= '0;
      cnt_l <= '0;
    end else begin
      if (!f_req || f_gnt)        cnt_f <= '0;
      else if (cnt_f != STARVE_LIM) cnt_f <= cnt_f + 8'd1;
      if (!l_req || l_gnt)        cnt_l <= '0;
      else if (cnt_l != STARVE_LIM) cnt_l <= cnt_l + 8'd1;
    end
  end

  // ---- stage p1: RAM read data returns one cycle after the granted read ----
  always_ff @(posedge clk1) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      own_p1 <= '0;
    end else begin
      vld_p1 <= mem_en && !mem_we;
      own_p1 <= d_gnt ? OWN_D : f_gnt ? OWN_F : l_gnt ? OWN_L : 2'd0;
    end
  end

  assign d_rvalid = !rst && vld_p1 && (own_p1 == OWN_D);
  assign f_rvalid = !rst && vld_p1 && (own_p1 == OWN_F);
  assign l_rvalid = !rst && vld_p1 && (own_p1 == OWN_L);
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1024x32 synchronous RAM.
module tb_mem_port_arbiter;

  logic        clk1, rst;
  logic        d_req, d_we, f_req, f_we, l_req, l_we, l_lock;
  logic [9:0]  d_addr, f_addr, l_addr;
  logic [31:0] d_wdata, f_wdata, l_wdata;
  logic        d_gnt, f_gnt, l_gnt, d_rvalid, f_rvalid, l_rvalid;
  logic [31:0] d_rdata, f_rdata, l_rdata;
  logic        mem_en, mem_we, starve_evt;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [0:1023];

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk1(clk1), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_lock(l_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_evt(starve_evt)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // RAM: preload while the bench holds reset, write-then-read ordering otherwise.
  always @(posedge clk1) begin
    if (rst) begin
      ram[10'h010] <= 32'hAAAA0001;
      ram[10'h020] <= 32'hBBBB0002;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic req, input logic we, input logic [9:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic set_f(input logic req, input logic [9:0] a);
    f_req = req; f_we = 1'b0; f_addr = a; f_wdata = '0;
  endtask

  task automatic set_l(input logic req, input logic lock, input logic [9:0] a);
    l_req = req; l_lock = lock; l_we = 1'b1; l_addr = a;
    l_wdata = 32'h5000_0000 | 32'(a);
  endtask

  task automatic gnts(input string tag, input logic ed, input logic ef, input logic el);
    @(negedge clk1);
    chk1({tag, "_d_gnt"}, d_gnt, ed);
    chk1({tag, "_f_gnt"}, f_gnt, ef);
    chk1({tag, "_l_gnt"}, l_gnt, el);
  endtask

  initial begin
    rst = 1'b1;
    set_d(1'b1, 1'b0, 10'h000, '0);
    set_f(1'b1, 10'h000);
    set_l(1'b1, 1'b0, 10'h000);

    // Reset with every request high
    for (int i = 0; i < 2; i++) begin
      tick();
      gnts("rst", 1'b0, 1'b0, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_d_rvalid", d_rvalid, 1'b0);
      chk1("rst_f_rvalid", f_rvalid, 1'b0);
      chkw("rst_mem_addr", 32'(mem_addr), 32'h0);
    end
    tick();
    rst = 1'b0;
    gnts("rel", 1'b1, 1'b0, 1'b0);
    tick();
    set_d(1'b0, 1'b0, 10'h000, '0);
    set_f(1'b0, 10'h000);
    set_l(1'b0, 1'b0, 10'h000);
    tick();

    // Priority and read routing
    set_d(1'b1, 1'b0, 10'h010, '0);
    set_f(1'b1, 10'h020);
    gnts("pri0", 1'b1, 1'b0, 1'b0);
    chkw("pri0_addr", 32'(mem_addr), 32'h010);
    tick();
    set_d(1'b0, 1'b0, 10'h000, '0);
    gnts("pri1", 1'b0, 1'b1, 1'b0);
    chk1("pri1_d_rvalid", d_rvalid, 1'b1);
    chkw("pri1_d_rdata", d_rdata, 32'hAAAA0001);
    chk1("pri1_f_rvalid", f_rvalid, 1'b0);
    chkw("pri1_addr", 32'(mem_addr), 32'h020);
    tick();
    set_f(1'b0, 10'h000);
    @(negedge clk1);
    chk1("pri2_f_rvalid", f_rvalid, 1'b1);
    chkw("pri2_f_rdata", f_rdata, 32'hBBBB0002);
    chk1("pri2_d_rvalid", d_rvalid, 1'b0);
    chkw("pri2_d_rdata", d_rdata, 32'h0);
    tick();

    // F starvation under continuous D traffic
    set_d(1'b1, 1'b0, 10'h000, '0);
    set_f(1'b1, 10'h020);
    for (int i = 0; i < 8; i++) begin
      gnts("stv_wait", 1'b1, 1'b0, 1'b0);
      tick();
    end
    gnts("stv_promo", 1'b0, 1'b1, 1'b0);
    chk1("stv_evt", starve_evt, 1'b1);
    tick();
    set_f(1'b0, 10'h000);
    gnts("stv_after", 1'b1, 1'b0, 1'b0);
    chk1("stv_evt_clr", starve_evt, 1'b0);
    chkw("stv_cnt_f", 32'(dut.cnt_f), 32'h0);
    chk1("stv_f_rvalid", f_rvalid, 1'b1);
    chkw("stv_f_rdata", f_rdata, 32'hBBBB0002);
    tick();
    set_d(1'b0, 1'b0, 10'h000, '0);
    tick();

    // Loader lock burst against continuous D traffic
    set_d(1'b1, 1'b0, 10'h000, '0);
    set_l(1'b1, 1'b1, 10'h100);
    for (int i = 0; i < 8; i++) begin
      gnts("lk_wait", 1'b1, 1'b0, 1'b0);
      tick();
    end
    gnts("lk_acq", 1'b0, 1'b0, 1'b1);
    chk1("lk_acq_evt", starve_evt, 1'b1);
    chk1("lk_acq_we", mem_we, 1'b1);
    chkw("lk_acq_addr", 32'(mem_addr), 32'h100);
    chkw("lk_acq_wdata", mem_wdata, 32'h50000100);
    tick();
    // Acquiring grant is followed by LOCK_MAX locked grants before cooldown
    for (int i = 1; i <= 16; i++) begin
      set_l(1'b1, 1'b1, 10'(10'h100 + i));
      gnts("lk_burst", 1'b0, 1'b0, 1'b1);
      chkw("lk_burst_addr", 32'(mem_addr), 32'h100 + 32'(i));
      tick();
    end
    set_l(1'b1, 1'b1, 10'h111);
    gnts("lk_cool", 1'b1, 1'b0, 1'b0);
    chk1("lk_cool_evt", starve_evt, 1'b0);
    tick();
    for (int i = 0; i < 7; i++) begin
      gnts("lk_rewait", 1'b1, 1'b0, 1'b0);
      tick();
    end
    gnts("lk_reacq", 1'b0, 1'b0, 1'b1);
    chk1("lk_reacq_evt", starve_evt, 1'b1);
    chkw("lk_reacq_addr", 32'(mem_addr), 32'h111);
    tick();
    set_l(1'b1, 1'b1, 10'h112);
    gnts("lk_held", 1'b0, 1'b0, 1'b1);
    tick();
    set_l(1'b0, 1'b0, 10'h000);
    gnts("lk_drop", 1'b0, 1'b0, 1'b0);
    chk1("lk_drop_en", mem_en, 1'b0);
    tick();
    gnts("lk_free", 1'b1, 1'b0, 1'b0);
    tick();

    // Burst data readback and write-then-read ordering
    set_d(1'b1, 1'b0, 10'h105, '0);
    tick();
    set_d(1'b1, 1'b1, 10'h200, 32'hCAFEF00D);
    @(negedge clk1);
    chk1("rb_rvalid", d_rvalid, 1'b1);
    chkw("rb_rdata", d_rdata, 32'h50000105);
    tick();
    set_d(1'b1, 1'b0, 10'h200, '0);
    @(negedge clk1);
    chk1("wr_no_rvalid", d_rvalid, 1'b0);
    tick();
    set_d(1'b0, 1'b0, 10'h000, '0);
    @(negedge clk1);
    chkw("wtr_rdata", d_rdata, 32'hCAFEF00D);
    tick();

    // Lock held while the loader idles
    set_l(1'b1, 1'b1, 10'h180);
    gnts("ih_acq", 1'b0, 1'b0, 1'b1);
    tick();
    set_l(1'b0, 1'b1, 10'h000);
    set_d(1'b1, 1'b0, 10'h000, '0);
    set_f(1'b1, 10'h020);
    for (int i = 0; i < 3; i++) begin
      gnts("ih_idle", 1'b0, 1'b0, 1'b0);
      chk1("ih_idle_en", mem_en, 1'b0);
      tick();
    end
    l_lock = 1'b0;
    gnts("ih_unlock", 1'b0, 1'b0, 1'b0);
    tick();
    gnts("ih_free", 1'b1, 1'b0, 1'b0);
    tick();
    set_d(1'b0, 1'b0, 10'h000, '0);
    set_f(1'b0, 10'h000);
    tick();

    // Reset right after an F read grant
    set_f(1'b1, 10'h020);
    set_l(1'b1, 1'b0, 10'h1F1);
    gnts("rm_fgnt", 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    set_f(1'b0, 10'h000);
    gnts("rm_rst", 1'b0, 1'b0, 1'b0);
    chk1("rm_f_rvalid", f_rvalid, 1'b0);
    chkw("rm_f_rdata", f_rdata, 32'h0);
    tick();
    rst = 1'b0;
    set_l(1'b0, 1'b0, 10'h000);
    @(negedge clk1);
    chk1("rm_f_rvalid_post", f_rvalid, 1'b0);
    chkw("rm_cnt_l", 32'(dut.cnt_l), 32'h0);
    tick();

    // Reset while locked releases the lock
    set_l(1'b1, 1'b1, 10'h1F2);
    gnts("rl_acq", 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_d(1'b1, 1'b0, 10'h000, '0);
    gnts("rl_after", 1'b1, 1'b0, 1'b0);
    chkw("rl_state", 32'(dut.state), 32'h0);
    chkw("rl_lock_cnt", 32'(dut.lock_cnt), 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
